// File: rtl/uart_defs.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_defs;

    // System clocks per bit for 115200 baud from the 144 MHz clock.
    localparam int unsigned UART_CLOCKS_PER_BIT_115200 = 32'd1250;

    // Payload bits per frame (8N1).
    localparam int unsigned UART_DATA_BITS = 32'd8;

    // Line state machine encoding.
    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit period timer: counts 0..CLOCKS_PER_BIT-1 and flags the last cycle of
// every bit period. A restart realigns the period to the current cycle so a
// new frame always starts with a full-length start bit.
module uart_bit_timer #(
    parameter int unsigned CLOCKS_PER_BIT = 32'd1250
) (
    input  logic clock_144mhz,
    input  logic reset_n,
    input  logic restart,
    output logic bit_tick
);

    localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLOCKS_PER_BIT - 32'd1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             bit_tick_r;

    // Next count: clear on restart, wrap after the last cycle of a bit.
    always_comb begin
        count_next_s = count_r;
        if (restart) begin
            count_next_s = '0;
        end else if (count_r == LAST_COUNT) begin
            count_next_s = '0;
        end else begin
            count_next_s = count_r + CNT_W'(1);
        end
    end

    // Counter and tick registers; the tick is high exactly while the
    // counter sits on its final value, so it lasts one cycle per bit.
    always_ff @(posedge clock_144mhz or negedge reset_n) begin
        if (!reset_n) begin
            count_r    <= '0;
            bit_tick_r <= 1'b0;
        end else begin
            count_r    <= count_next_s;
            bit_tick_r <= (count_next_s == LAST_COUNT);
        end
    end

    assign bit_tick = bit_tick_r;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter. A one-byte holding register decouples the producer
// handshake from the line so the next byte can be queued during a frame and
// sent with no idle gap after the final stop bit.
module uart_transmitter
    import uart_defs::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT_115200,
    parameter int unsigned STOP_BITS      = 32'd1
) (
    input  logic       clock_144mhz,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       uart_tx,
    output logic       busy
);

    localparam logic [2:0] LAST_DATA_IDX = 3'(UART_DATA_BITS - 32'd1);
    localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 32'd1);

    uart_state_e state_r;
    logic [7:0]  shift_r;
    logic [7:0]  hold_r;
    logic        hold_full_r;
    logic [2:0]  bit_idx_r;
    logic        uart_tx_r;
    logic        data_ready_r;
    logic        busy_r;

    logic        bit_tick_s;
    logic        handshake_s;
    logic        stop_end_s;
    logic        load_s;
    logic        hold_full_next_s;
    logic        busy_next_s;

    // Frame events and next-cycle values of the handshake/status flags.
    always_comb begin
        handshake_s = data_valid && data_ready_r;
        stop_end_s  = (state_r == UART_STOP) && bit_tick_s &&
                      (bit_idx_r == LAST_STOP_IDX);
        // A queued byte moves to the shifter either from idle or straight
        // out of the last stop bit, which gives back-to-back frames.
        load_s      = hold_full_r && ((state_r == UART_IDLE) || stop_end_s);
        if (load_s) begin
            hold_full_next_s = 1'b0;
        end else if (handshake_s) begin
            hold_full_next_s = 1'b1;
        end else begin
            hold_full_next_s = hold_full_r;
        end
        busy_next_s = hold_full_next_s || load_s ||
                      ((state_r != UART_IDLE) && !stop_end_s);
    end

    uart_bit_timer #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
    ) u_bit_timer (
        .clock_144mhz (clock_144mhz),
        .reset_n      (reset_n),
        .restart      (load_s),
        .bit_tick     (bit_tick_s)
    );

    // Holding register: loaded on handshake, emptied when copied out.
    always_ff @(posedge clock_144mhz or negedge reset_n) begin
        if (!reset_n) begin
            hold_r      <= 8'h00;
            hold_full_r <= 1'b0;
        end else begin
            if (handshake_s) begin
                hold_r <= data;
            end else begin
                hold_r <= hold_r;
            end
            hold_full_r <= hold_full_next_s;
        end
    end

    // Line FSM with shift register, bit index and registered outputs.
    always_ff @(posedge clock_144mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= UART_IDLE;
            shift_r      <= 8'h00;
            bit_idx_r    <= 3'd0;
            uart_tx_r    <= 1'b1;
            data_ready_r <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            // Ready mirrors an empty holding register one cycle later, so
            // a handshake can never coincide with a transfer out of it.
            data_ready_r <= !hold_full_next_s;
            busy_r       <= busy_next_s;
            case (state_r)
                UART_IDLE: begin
                    bit_idx_r <= 3'd0;
                    if (load_s) begin
                        shift_r   <= hold_r;
                        state_r   <= UART_START;
                        uart_tx_r <= 1'b0;
                    end else begin
                        uart_tx_r <= 1'b1;
                    end
                end
                UART_START: begin
                    if (bit_tick_s) begin
                        state_r   <= UART_DATA;
                        bit_idx_r <= 3'd0;
                        uart_tx_r <= shift_r[0];
                    end else begin
                        uart_tx_r <= 1'b0;
                    end
                end
                UART_DATA: begin
                    if (bit_tick_s) begin
                        if (bit_idx_r == LAST_DATA_IDX) begin
                            state_r   <= UART_STOP;
                            bit_idx_r <= 3'd0;
                            uart_tx_r <= 1'b1;
                        end else begin
                            // Present the next bit while the shifter
                            // advances, keeping the line registered.
                            shift_r   <= shift_r >> 1;
                            bit_idx_r <= bit_idx_r + 3'd1;
                            uart_tx_r <= shift_r[1];
                        end
                    end else begin
                        uart_tx_r <= shift_r[0];
                    end
                end
                UART_STOP: begin
                    if (stop_end_s) begin
                        bit_idx_r <= 3'd0;
                        if (load_s) begin
                            shift_r   <= hold_r;
                            state_r   <= UART_START;
                            uart_tx_r <= 1'b0;
                        end else begin
                            state_r   <= UART_IDLE;
                            uart_tx_r <= 1'b1;
                        end
                    end else if (bit_tick_s) begin
                        bit_idx_r <= bit_idx_r + 3'd1;
                        uart_tx_r <= 1'b1;
                    end else begin
                        uart_tx_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= UART_IDLE;
                    bit_idx_r <= 3'd0;
                    uart_tx_r <= 1'b1;
                end
            endcase
        end
    end

    assign data_ready = data_ready_r;
    assign uart_tx    = uart_tx_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: three instances (fast 10-clock bits,
// 4-clock bits with two stop bits, and the 1250-clock default) driven and
// sampled on the falling clock edge.
module tb_uart_transmitter;

    localparam int A_CPB = 10;
    localparam int B_CPB = 4;
    localparam int B_STOP = 2;
    localparam int C_CPB = 1250;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_rst_n, rst_n;
    logic [7:0] a_data, b_data, c_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_ready, b_ready, c_ready;
    logic       a_tx, b_tx, c_tx;
    logic       a_busy, b_busy, c_busy;

    uart_transmitter #(.CLOCKS_PER_BIT(A_CPB), .STOP_BITS(1)) dut_a (
        .clock_144mhz(clk), .reset_n(a_rst_n), .data(a_data), .data_valid(a_valid),
        .data_ready(a_ready), .uart_tx(a_tx), .busy(a_busy));

    uart_transmitter #(.CLOCKS_PER_BIT(B_CPB), .STOP_BITS(B_STOP)) dut_b (
        .clock_144mhz(clk), .reset_n(rst_n), .data(b_data), .data_valid(b_valid),
        .data_ready(b_ready), .uart_tx(b_tx), .busy(b_busy));

    uart_transmitter dut_c (
        .clock_144mhz(clk), .reset_n(rst_n), .data(c_data), .data_valid(c_valid),
        .data_ready(c_ready), .uart_tx(c_tx), .busy(c_busy));

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int hs_a = 0;
    always @(posedge clk) if (a_rst_n && a_valid && a_ready) hs_a <= hs_a + 1;

    function automatic logic tx_of(input int sel);
        case (sel)
            0: return a_tx;
            1: return b_tx;
            default: return c_tx;
        endcase
    endfunction

    function automatic logic ready_of(input int sel);
        case (sel)
            0: return a_ready;
            1: return b_ready;
            default: return c_ready;
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        case (sel)
            0: begin a_valid = v; a_data = d; end
            1: begin b_valid = v; b_data = d; end
            default: begin c_valid = v; c_data = d; end
        endcase
    endtask

    // Offer a byte (call at a falling edge); returns at the falling edge
    // after the handshake edge. keep leaves data_valid asserted.
    task automatic send(input int sel, input logic [7:0] d, input bit keep, output int hs_edge);
        int w;
        w = 0;
        hs_edge = -1000000;
        drive(sel, 1'b1, d);
        while (ready_of(sel) !== 1'b1 && w < 30000) begin
            @(negedge clk);
            w++;
        end
        if (ready_of(sel) !== 1'b1) begin
            check_val("send_ready_timeout", 32'd0, 32'd1);
            drive(sel, 1'b0, d);
        end else begin
            hs_edge = cyc + 1;
            @(negedge clk);
            if (!keep) drive(sel, 1'b0, d);
        end
    endtask

    logic [7:0] rx_byte_q[$];
    int         rx_start_q[$];
    int         rx_bad = 0;

    // Receive one frame, checking every cycle of every bit for the level
    // established on the first cycle of that bit.
    task automatic rx_one(input int sel, input int cpb, input int stopb);
        int waited;
        logic val, v;
        logic [7:0] b;
        waited = 0;
        val = 1'b1;
        b = 8'h00;
        @(negedge clk);
        while (tx_of(sel) !== 1'b0 && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        if (tx_of(sel) !== 1'b0) begin
            check_val("rx_start_seen", 32'd0, 32'd1);
            return;
        end
        rx_start_q.push_back(cyc);
        for (int bi = 0; bi < 9 + stopb; bi++) begin
            for (int c = 0; c < cpb; c++) begin
                if (bi != 0 || c != 0) @(negedge clk);
                v = tx_of(sel);
                if (c == 0) begin
                    val = v;
                    if (bi == 0 && v !== 1'b0) rx_bad++;
                    if (bi >= 1 && bi <= 8) b[bi-1] = v;
                    if (bi >= 9 && v !== 1'b1) rx_bad++;
                end else if (v !== val) begin
                    rx_bad++;
                end
            end
        end
        rx_byte_q.push_back(b);
    endtask

    task automatic rx_n(input int sel, input int cpb, input int stopb, input int n);
        for (int i = 0; i < n; i++) rx_one(sel, cpb, stopb);
    endtask

    task automatic pop_rx(output logic [7:0] b, output int s);
        if (rx_byte_q.size() == 0 || rx_start_q.size() == 0) begin
            b = 'x;
            s = -1000000;
        end else begin
            b = rx_byte_q.pop_front();
            s = rx_start_q.pop_front();
        end
    endtask

    task automatic rx_clear();
        rx_byte_q.delete();
        rx_start_q.delete();
        rx_bad = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int h0, h1, h2, s0, s1, s2, s3, hsb, bad, k;
    logic [7:0] r0, r1, r2, r3;

    initial begin
        a_rst_n = 1'b0; rst_n = 1'b0;
        drive(0, 1'b0, 8'h00); drive(1, 1'b0, 8'h00); drive(2, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check_val("rst_tx", 32'(a_tx), 32'd1);
        check_val("rst_ready", 32'(a_ready), 32'd1);
        check_val("rst_busy", 32'(a_busy), 32'd0);
        a_rst_n = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_tx", 32'(c_tx), 32'd1);
        check_val("post_rst_ready", 32'(c_ready), 32'd1);
        check_val("post_rst_busy", 32'(b_busy), 32'd0);

        // Default rate, 0x55: latency, exact bit timing, busy release.
        rx_clear();
        fork
            rx_n(2, C_CPB, 1, 1);
            begin
                send(2, 8'h55, 1'b0, h0);
                check_val("t1_tx_before_start", 32'(c_tx), 32'd1);
                check_val("t1_ready_low", 32'(c_ready), 32'd0);
                check_val("t1_busy_high", 32'(c_busy), 32'd1);
                @(negedge clk);
                @(negedge clk);
                check_val("t1_ready_back", 32'(c_ready), 32'd1);
            end
        join
        pop_rx(r0, s0);
        check_val("t1_latency", 32'(s0 - h0), 32'd1);
        check_val("t1_byte", 32'(r0), 32'h55);
        check_val("t1_bit_timing", 32'(rx_bad), 32'd0);
        check_val("t1_busy_last_stop", 32'(c_busy), 32'd1);
        @(negedge clk);
        check_val("t1_busy_fall", 32'(c_busy), 32'd0);
        check_val("t1_busy_fall_cycle", 32'(cyc - h0), 32'd12501);

        // 0xA5 then 0x0F offered while ready is low: back-to-back frames.
        rx_clear();
        fork
            rx_n(0, A_CPB, 1, 2);
            begin
                send(0, 8'hA5, 1'b0, h0);
                check_val("t2_ready_low_offer", 32'(a_ready), 32'd0);
                send(0, 8'h0F, 1'b0, h1);
            end
        join
        pop_rx(r0, s0);
        pop_rx(r1, s1);
        check_val("t2_latency", 32'(s0 - h0), 32'd1);
        check_val("t2_byte0", 32'(r0), 32'hA5);
        check_val("t2_byte1", 32'(r1), 32'h0F);
        check_val("t2_spacing", 32'(s1 - s0), 32'd100);
        check_val("t2_bit_timing", 32'(rx_bad), 32'd0);
        repeat (3) @(negedge clk);

        // data_valid held high with 0x00..0x03: four contiguous frames.
        rx_clear();
        hsb = hs_a;
        fork
            rx_n(0, A_CPB, 1, 4);
            begin
                for (int i = 0; i < 4; i++) send(0, 8'(i), 1'b1, h0);
                drive(0, 1'b0, 8'h00);
            end
        join
        pop_rx(r0, s0); pop_rx(r1, s1); pop_rx(r2, s2); pop_rx(r3, s3);
        check_val("t3_handshakes", 32'(hs_a - hsb), 32'd4);
        check_val("t3_bytes", {r3, r2, r1, r0}, 32'h03020100);
        check_val("t3_gap01", 32'(s1 - s0), 32'd100);
        check_val("t3_gap12", 32'(s2 - s1), 32'd100);
        check_val("t3_gap23", 32'(s3 - s2), 32'd100);
        check_val("t3_bit_timing", 32'(rx_bad), 32'd0);
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of 0xFF, then a clean 0x81.
        send(0, 8'hFF, 1'b0, h0);
        repeat (46) @(negedge clk);
        check_val("t4_busy_mid_frame", 32'(a_busy), 32'd1);
        a_rst_n = 1'b0;
        #1;
        check_val("t4_rst_tx", 32'(a_tx), 32'd1);
        check_val("t4_rst_busy", 32'(a_busy), 32'd0);
        check_val("t4_rst_ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        a_rst_n = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1) bad++;
        end
        check_val("t4_quiet_after_rst", 32'(bad), 32'd0);
        rx_clear();
        fork
            rx_n(0, A_CPB, 1, 1);
            send(0, 8'h81, 1'b0, h0);
        join
        pop_rx(r0, s0);
        check_val("t4_byte", 32'(r0), 32'h81);
        check_val("t4_latency", 32'(s0 - h0), 32'd1);
        check_val("t4_bit_timing", 32'(rx_bad), 32'd0);
        repeat (3) @(negedge clk);

        // 4 clocks per bit, two stop bits: 0x80 then 0x3C, 44-cycle frames.
        rx_clear();
        fork
            rx_n(1, B_CPB, B_STOP, 2);
            begin
                send(1, 8'h80, 1'b0, h0);
                send(1, 8'h3C, 1'b0, h1);
            end
        join
        pop_rx(r0, s0);
        pop_rx(r1, s1);
        check_val("t5_latency", 32'(s0 - h0), 32'd1);
        check_val("t5_byte0", 32'(r0), 32'h80);
        check_val("t5_byte1", 32'(r1), 32'h3C);
        check_val("t5_frame_len", 32'(s1 - s0), 32'd44);
        check_val("t5_bit_timing", 32'(rx_bad), 32'd0);
        check_val("t5_busy_last_stop", 32'(b_busy), 32'd1);
        @(negedge clk);
        check_val("t5_busy_fall", 32'(b_busy), 32'd0);
        check_val("t5_busy_fall_cycle", 32'(cyc - s1), 32'd44);

        // valid toggled with changing data while ready is low.
        rx_clear();
        hsb = hs_a;
        k = 0;
        fork
            rx_n(0, A_CPB, 1, 3);
            begin
                send(0, 8'h11, 1'b0, h0);
                send(0, 8'h22, 1'b0, h1);
                while (a_ready !== 1'b1 && k < 500) begin
                    a_valid = ~a_valid;
                    a_data = 8'h40 + 8'(k);
                    k++;
                    @(negedge clk);
                end
                send(0, 8'h99, 1'b0, h2);
            end
        join
        pop_rx(r0, s0); pop_rx(r1, s1); pop_rx(r2, s2);
        check_val("t6_bytes", {8'h00, r2, r1, r0}, 32'h00992211);
        check_val("t6_handshakes", 32'(hs_a - hsb), 32'd3);
        check_val("t6_gap01", 32'(s1 - s0), 32'd100);
        check_val("t6_bit_timing", 32'(rx_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
